// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: resolves load-use, taken-branch and multi-cycle multiply hazards.
// Outputs are combinational from state and inputs; state and stall counter are registered.
module pipe_hazard_ctl #(
  parameter int REGW     = 5,
  parameter int MULT_LAT = 4,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_valid,
  input  logic            ex_is_load,
  input  logic [REGW-1:0] ex_rd,
  input  logic            br_taken,
  input  logic            mul_start,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            idex_we,
  output logic            ifid_ctl,
  output logic            idex_ctl,
  output logic            exmem_ctl,
  output logic [CNTW-1:0] stall_cycles
);

  typedef enum logic [1:0] {HOLD, RUN, MUL} state_t;

  state_t          state_q, state_d;
  logic [3:0]      mcnt_q, mcnt_d;
  logic [CNTW-1:0] stall_cycles_q, stall_cycles_d;
  logic            load_use;

  always_comb begin
    load_use = ex_valid && ex_is_load && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    state_d   = state_q;
    mcnt_d    = mcnt_q;
    pc_we     = 1'b0;
    ifid_we   = 1'b0;
    idex_we   = 1'b0;
    ifid_ctl  = 1'b0;
    idex_ctl  = 1'b0;
    exmem_ctl = 1'b0;
    case (state_q)
      HOLD: state_d = RUN;
      RUN: begin
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        idex_we   = 1'b1;
        ifid_ctl  = 1'b1;
        idex_ctl  = 1'b1;
        exmem_ctl = 1'b1;
        if (br_taken) begin
          ifid_ctl = 1'b0;
          idex_ctl = 1'b0;
        end else if (mul_start) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_we   = 1'b0;
          exmem_ctl = 1'b0;
          // The mul_start cycle is the first stall cycle; MUL covers the remaining MULT_LAT-2.
          if (MULT_LAT != 2) begin
            state_d = MUL;
            mcnt_d  = 4'(MULT_LAT - 3);
          end
        end else if (load_use) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_ctl = 1'b0;
        end
      end
      MUL: begin
        ifid_ctl = 1'b1;
        idex_ctl = 1'b1;
        if (mcnt_q == 4'd0) state_d = RUN;
        else                mcnt_d  = mcnt_q - 4'd1;
      end
      default: state_d = HOLD;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((state_q != HOLD) && !pc_we && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= HOLD;
      mcnt_q         <= 4'd0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mcnt_q         <= mcnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
